// File: rtl/uart_tx_frame.sv
`default_nettype none
// ==== uart_tx_frame : UART transmitter, configurable data width / parity / stop bits. Rev 1.0 ====
// ==== Optional input FIFO enabled by defining macro UART_TX_FIFO_EN.                            ====
module uart_tx_frame #(
  parameter int DATA_W       = 8,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 27,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk_3125,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);
  localparam int CNT_W   = $clog2(CLKS_PER_BIT);
  localparam int IDX_W   = $clog2(DATA_W + 1);
  localparam bit HAS_PAR = (PARITY_MODE == 1) || (PARITY_MODE == 2);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] BIT_PRE  = CNT_W'(CLKS_PER_BIT - 2);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_parity
    $error("uart_tx_frame: PARITY_MODE=%0d is illegal, frames are sent without parity", PARITY_MODE);
  end
  if (CLKS_PER_BIT < 2 || FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_cfg
    $error("uart_tx_frame: CLKS_PER_BIT must be >= 2 and FIFO_DEPTH a power of two >= 2");
  end

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } state_t;

  state_t            state;
  logic [CNT_W-1:0]  bit_cnt;
  logic [IDX_W-1:0]  bit_idx;
  logic              stop_cnt;
  logic [DATA_W-1:0] shreg;
  logic              par_bit;
  logic              busy_frame;
  logic              bit_end;
  logic              last_stop;
  logic              stop_final;
  logic              can_load;
  logic              load;
  logic [DATA_W-1:0] load_word;

  assign bit_end    = (bit_cnt == BIT_LAST);
  assign last_stop  = (state == STOP) && (stop_cnt == 1'(STOP_BITS - 1));
  assign stop_final = last_stop && bit_end;
  // Reloading in the final stop cycle gives back-to-back frames with no idle gap.
  assign can_load   = (state == IDLE) || stop_final;

`ifdef UART_TX_FIFO_EN
  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_W-1:0] mem [FIFO_DEPTH];
  logic [AW:0]       wr_ptr;
  logic [AW:0]       rd_ptr;
  logic              empty;
  logic              full;
  logic              push;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign s_ready   = rst_n && !full;
  assign push      = s_valid && s_ready;
  assign load      = can_load && !empty;
  assign load_word = mem[rd_ptr[AW-1:0]];
  assign busy      = busy_frame || !empty;

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk_3125) begin
    if (push) mem[wr_ptr[AW-1:0]] <= s_data;
  end
`else
  assign s_ready   = rst_n && can_load;
  assign load      = s_valid && s_ready;
  assign load_word = s_data;
  assign busy      = busy_frame;
`endif

  always_ff @(posedge clk_3125 or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      bit_cnt    <= '0;
      bit_idx    <= '0;
      stop_cnt   <= 1'b0;
      shreg      <= '0;
      par_bit    <= 1'b0;
      tx         <= 1'b1;
      busy_frame <= 1'b0;
      tx_done    <= 1'b0;
    end else begin
      // Registered pulse: set one cycle ahead so it lands on the final stop cycle.
      tx_done <= last_stop && (bit_cnt == BIT_PRE);
      if (state == IDLE) bit_cnt <= '0;
      else               bit_cnt <= bit_end ? '0 : bit_cnt + 1'b1;

      case (state)
        START: if (bit_end) begin
          state   <= DATA;
          tx      <= shreg[0];
          shreg   <= shreg >> 1;
          bit_idx <= '0;
        end
        DATA: if (bit_end) begin
          if (bit_idx == IDX_LAST) begin
            if (HAS_PAR) begin
              state <= PARITY;
              tx    <= par_bit;
            end else begin
              state    <= STOP;
              tx       <= 1'b1;
              stop_cnt <= 1'b0;
            end
          end else begin
            bit_idx <= bit_idx + 1'b1;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        PARITY: if (bit_end) begin
          state    <= STOP;
          tx       <= 1'b1;
          stop_cnt <= 1'b0;
        end
        STOP: begin
          if (bit_end && !last_stop) begin
            stop_cnt <= stop_cnt + 1'b1;
          end else if (stop_final) begin
            state      <= IDLE;
            busy_frame <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase

      // A new word overrides whatever the frame logic above decided.
      if (load) begin
        state      <= START;
        tx         <= 1'b0;
        busy_frame <= 1'b1;
        shreg      <= load_word;
        par_bit    <= (PARITY_MODE == 2) ? ~^load_word : ^load_word;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_frame.sv
`default_nettype none
// tb_uart_tx_frame: four parameterisations of uart_tx_frame checked every cycle against a frame-level model.
`timescale 1ns/1ps
module tb_uart_tx_frame;
  localparam int NCFG   = 4;
  localparam int FDEPTH = 4;
`ifdef UART_TX_FIFO_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  function automatic int cfg_dw(int i);
    case (i) 1: return 7; 3: return 9; default: return 8; endcase
  endfunction
  function automatic int cfg_pm(int i);
    case (i) 1: return 2; 2: return 0; default: return 1; endcase
  endfunction
  function automatic int cfg_sb(int i);
    return (i == 2) ? 2 : 1;
  endfunction
  function automatic int cfg_cpb(int i);
    return (i == 3) ? 3 : 4;
  endfunction

  logic clk_3125 = 1'b0;
  always #5 clk_3125 = ~clk_3125;

  logic            rst_n;
  logic [8:0]      sd [NCFG];
  logic [NCFG-1:0] sv;
  logic [NCFG-1:0] rdy_v, tx_v, busy_v, done_v;
  int total = 0;
  int bad   = 0;

  task automatic chk(string name, int cfg, logic [31:0] act, logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cfg%0d t=%0t: got %0h expected %0h", name, cfg, $time, act, exp);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int DW  = cfg_dw(g);
    localparam int PM  = cfg_pm(g);
    localparam int SB  = cfg_sb(g);
    localparam int CPB = cfg_cpb(g);
    logic rdy, txl, bsy, dn;

    uart_tx_frame #(
      .DATA_W(DW), .PARITY_MODE(PM), .STOP_BITS(SB), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(FDEPTH)
    ) u_dut (
      .clk_3125(clk_3125), .rst_n(rst_n), .s_data(sd[g][DW-1:0]), .s_valid(sv[g]),
      .s_ready(rdy), .tx(txl), .busy(bsy), .tx_done(dn)
    );
    assign rdy_v[g]  = rdy;
    assign tx_v[g]   = txl;
    assign busy_v[g] = bsy;
    assign done_v[g] = dn;

    // Expected line, one entry per clock: bit0 = tx, bit1 = last cycle of frame.
    logic [1:0] line_q [$];
    logic [8:0] word_q [$];

    task automatic push_frame(logic [8:0] w);
      logic b [$];
      int   ones;
      ones = $countones(w[DW-1:0]);
      b.push_back(1'b0);
      for (int j = 0; j < DW; j++) b.push_back(w[j]);
      if (PM == 1) b.push_back(1'(ones % 2));
      if (PM == 2) b.push_back(1'(1 - ones % 2));
      for (int j = 0; j < SB; j++) b.push_back(1'b1);
      for (int j = 0; j < b.size(); j++)
        for (int c = 0; c < CPB; c++)
          line_q.push_back({(j == b.size() - 1) && (c == CPB - 1), b[j]});
    endtask

    always @(negedge clk_3125) begin : p_check
      logic [1:0] e;
      logic       live;
      logic       exp_rdy;
      if (!rst_n) begin
        chk("reset_tx", g, tx_v[g], 1);
        chk("reset_busy", g, busy_v[g], 0);
        chk("reset_done", g, done_v[g], 0);
        chk("reset_ready", g, rdy_v[g], 0);
        line_q.delete();
        word_q.delete();
      end else begin
        live = (line_q.size() != 0);
        e    = live ? line_q.pop_front() : 2'b01;
`ifdef UART_TX_FIFO_EN
        exp_rdy = (word_q.size() < FDEPTH);
`else
        exp_rdy = !live || e[1];
`endif
        chk("tx", g, tx_v[g], e[0]);
        chk("busy", g, busy_v[g], live || (word_q.size() != 0));
        chk("tx_done", g, done_v[g], e[1]);
        chk("s_ready", g, rdy_v[g], exp_rdy);
`ifdef UART_TX_FIFO_EN
        if ((!live || e[1]) && word_q.size() != 0) push_frame(word_q.pop_front());
        if (sv[g] && exp_rdy) word_q.push_back(sd[g]);
`else
        if (sv[g] && exp_rdy) push_frame(sd[g]);
`endif
      end
    end
  end

  initial begin
    logic [10:0] exp0;
    logic        t0 [128];
    logic        t1 [128];
    logic        t2 [128];
    int          d0q [$];
    int          d1q [$];
    int          d2q [$];
    int          gaps;
    logic        drop;

    exp0 = 11'b10101001010;   // 0xA5 8E1: start, d0..d7, parity, stop (index 0 first)
    rst_n = 1'b0;
    sv    = '0;
    for (int i = 0; i < NCFG; i++) sd[i] = '0;
    repeat (3) @(posedge clk_3125);
    #1 rst_n = 1'b1;

    // Single frames on cfg0/1/3; cfg2 sends 0x00 then 0xFF with valid held.
    @(posedge clk_3125); #1;
    sv    = '1;
    sd[0] = 9'h0A5;
    sd[1] = 9'h07F;
    sd[2] = 9'h000;
    sd[3] = 9'($urandom);
    drop  = 1'b0;
    gaps  = 0;
    for (int k = 1; k <= 100; k++) begin
      @(posedge clk_3125); #1;
      if (k == 1) begin
        sv[0] = 1'b0; sv[1] = 1'b0; sv[3] = 1'b0;
        sd[2] = 9'h0FF;
      end
      if (drop) sv[2] = 1'b0;
      sd[0] = ~sd[0];
      sd[1] = ~sd[1];
      sd[3] = ~sd[3];
      @(negedge clk_3125);
      t0[k] = tx_v[0];
      t1[k] = tx_v[1];
      t2[k] = tx_v[2];
      if (done_v[0]) d0q.push_back(k);
      if (done_v[1]) d1q.push_back(k);
      if (done_v[2]) d2q.push_back(k);
      if (k >= LAT && k <= 87 + LAT && !busy_v[2]) gaps++;
      if (sv[2] && rdy_v[2]) drop = 1'b1;
    end

    for (int b = 0; b < 11; b++) begin
      int base;
      base = LAT - 1 + 4 * b;
      chk("a5_bit", 0, {t0[base+1], t0[base+2], t0[base+3], t0[base+4]}, {4{exp0[b]}});
    end
    chk("a5_done_count", 0, d0q.size(), 1);
    chk("a5_done_cycle", 0, (d0q.size() > 0) ? d0q[0] : -1, 43 + LAT);
    chk("7f_odd_parity", 1, {t1[LAT+32], t1[LAT+33], t1[LAT+34], t1[LAT+35]}, 4'h0);
    chk("7f_done_cycle", 1, (d1q.size() > 0) ? d1q[0] : -1, 39 + LAT);
    chk("b2b_done_count", 2, d2q.size(), 2);
    chk("b2b_done_first", 2, (d2q.size() > 0) ? d2q[0] : -1, 43 + LAT);
    chk("b2b_done_second", 2, (d2q.size() > 1) ? d2q[1] : -1, 87 + LAT);
    chk("b2b_second_start", 2, t2[44+LAT], 0);
    chk("b2b_busy_gaps", 2, gaps, 0);

    // Reset during the third data bit of 0x3C (cfg3 sends 0x00 so its line is low there).
    @(posedge clk_3125); #1;
    sv    = '1;
    sd[0] = 9'h03C; sd[1] = 9'h03C; sd[2] = 9'h03C; sd[3] = 9'h000;
    @(posedge clk_3125); #1;
    sv = '0;
    repeat (13) @(posedge clk_3125);
    #2;
    chk("pre_reset_tx", 3, tx_v[3], 0);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < NCFG; i++) chk("async_reset_tx", i, tx_v[i], 1);
    repeat (3) @(posedge clk_3125);
    #1 rst_n = 1'b1;

    @(posedge clk_3125); #1;
    sv = '1;
    for (int i = 0; i < NCFG; i++) sd[i] = 9'h081;
    @(posedge clk_3125); #1;
    sv = '0;
    repeat (60) @(posedge clk_3125);

    // Random traffic: data changes every cycle, valid asserted about 3 cycles in 4.
    for (int n = 0; n < 3000; n++) begin
      @(posedge clk_3125); #1;
      for (int i = 0; i < NCFG; i++) begin
        sd[i] = 9'($urandom);
        sv[i] = ($urandom_range(0, 3) != 0);
      end
    end
    @(posedge clk_3125); #1;
    sv = '0;
    repeat (300) @(posedge clk_3125);
    @(negedge clk_3125);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
